ps2_rx_fifo: RTL and testbench

- Memory-mapped PS/2 keyboard receiver for the picoversat data bus.
- Replaces the bare PS2 instance at the top level, which has one code output and a valid strobe, no buffering and no error reporting.
- Deserialises PS/2 device-to-host frames, checks odd parity, stop bit and inter-bit timeout, and buffers good scancodes in a parametrised FIFO.
- Software reads status and pops codes through the address decoder; `irq_o` flags pending codes.

---
 rtl/ps2_rx_fifo.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//   Memory-mapped PS/2 keyboard receiver. It deserialises device-to-host
//   frames, checks odd parity, the stop bit and the inter-bit timeout, and
//   buffers good scancodes in a small FIFO that software reads over the bus.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   sel, we       bus select and write enable (we qualifies sel)
//   addr          register index: 0 STATUS, 1 DATA (pop), 2 CLEAR (W1C), 3 none
//   data_in       bus write data
//   data_out      bus read data, combinational, 0 when not being read
//   ps2Clk/Data   PS/2 lines from the device, asynchronous to clk
//   code_valid    one-cycle pulse when a code enters the FIFO
//   irq_o         high while the FIFO holds at least one code
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
   parameter int DATA_W      = 32,
   parameter int FIFO_AW     = 3,
   parameter int TIMEOUT_CYC = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   input  logic              ps2Clk,
   input  logic              ps2Data,
   output logic              code_valid,
   output logic              irq_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- input synchronisers ----------------
   logic [SYNC_STAGES-1:0] clk_sync_reg;
   logic [SYNC_STAGES-1:0] data_sync_reg;
   logic                   clk_prev_reg;
   logic                   ps2_clk_s;
   logic                   ps2_data_s;
   logic                   ps2_fall;

   // Flops reset to 1 so a reset does not look like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_reg  <= '1;
         data_sync_reg <= '1;
         clk_prev_reg  <= 1'b1;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2Clk};
         data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2Data};
         clk_prev_reg  <= ps2_clk_s;
      end
   end

   assign ps2_clk_s  = clk_sync_reg[SYNC_STAGES-1];
   assign ps2_data_s = data_sync_reg[SYNC_STAGES-1];
   assign ps2_fall   = clk_prev_reg & ~ps2_clk_s;

   // ---------------- frame FSM ----------------
   state_t          state_reg;
   logic [2:0]      bit_cnt_reg;
   logic [7:0]      shift_reg;
   logic            parity_reg;
   logic [TO_W-1:0] to_cnt_reg;
   logic            push_pend_reg;
   logic [7:0]      push_code_reg;
   logic            perr_set_reg;
   logic            ferr_set_reg;
   logic            parity_ok;

   // Odd parity over the 8 data bits plus the received parity bit.
   assign parity_ok = ^{shift_reg, parity_reg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         parity_reg    <= 1'b0;
         to_cnt_reg    <= '0;
         push_pend_reg <= 1'b0;
         push_code_reg <= '0;
         perr_set_reg  <= 1'b0;
         ferr_set_reg  <= 1'b0;
      end else begin
         push_pend_reg <= 1'b0;
         perr_set_reg  <= 1'b0;
         ferr_set_reg  <= 1'b0;
         if (state_reg == S_IDLE) begin
            to_cnt_reg <= '0;
            if (ps2_fall && !ps2_data_s) begin
               state_reg   <= S_DATA;
               bit_cnt_reg <= '0;
            end
         end else if (ps2_fall) begin
            to_cnt_reg <= '0;
            case (state_reg)
               S_DATA: begin
                  shift_reg   <= {ps2_data_s, shift_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7)
                     state_reg <= S_PARITY;
               end
               S_PARITY: begin
                  parity_reg <= ps2_data_s;
                  state_reg  <= S_STOP;
               end
               S_STOP: begin
                  state_reg <= S_IDLE;
                  if (parity_ok && ps2_data_s) begin
                     push_pend_reg <= 1'b1;
                     push_code_reg <= shift_reg;
                  end
                  if (!parity_ok)  perr_set_reg <= 1'b1;
                  if (!ps2_data_s) ferr_set_reg <= 1'b1;
               end
               default: state_reg <= S_IDLE;
            endcase
         end else if (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
            // Device stalled mid-frame: drop the partial frame.
            state_reg    <= S_IDLE;
            to_cnt_reg   <= '0;
            ferr_set_reg <= 1'b1;
         end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
         end
      end
   end

   // ---------------- FIFO ----------------
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg;
   logic               fifo_empty;
   logic               fifo_full;
   logic               rd_sel;
   logic               pop;
   logic               push;
   logic               w1c;
   logic               parity_err_reg;
   logic               frame_err_reg;
   logic               overflow_reg;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == (FIFO_AW+1)'(DEPTH));
   assign rd_sel     = sel & ~we;
   assign pop        = rd_sel & (addr == 2'd1) & ~fifo_empty;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push       = push_pend_reg & (~fifo_full | pop);
   assign w1c        = sel & we & (addr == 2'd2);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= push_code_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (FIFO_AW+1)'(1);
            2'b01:   count_reg <= count_reg - (FIFO_AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Sticky flags; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         parity_err_reg <= (parity_err_reg & ~(w1c & data_in[2])) | perr_set_reg;
         frame_err_reg  <= (frame_err_reg  & ~(w1c & data_in[3])) | ferr_set_reg;
         overflow_reg   <= (overflow_reg   & ~(w1c & data_in[4]))
                           | (push_pend_reg & fifo_full & ~pop);
      end
   end

   // ---------------- bus read mux ----------------
   always_comb begin
      data_out = '0;
      if (rd_sel) begin
         case (addr)
            2'd0: begin
               data_out[0]             = fifo_empty;
               data_out[1]             = fifo_full;
               data_out[2]             = parity_err_reg;
               data_out[3]             = frame_err_reg;
               data_out[4]             = overflow_reg;
               data_out[8 +: FIFO_AW+1] = count_reg;
            end
            2'd1: begin
               if (!fifo_empty)
                  data_out[7:0] = mem[rd_ptr_reg];
            end
            default: data_out = '0;
         endcase
      end
   end

   assign code_valid = push;
   assign irq_o      = ~fifo_empty;

   // Bus write bits that have no register behind them.
   logic unused_data_in;
   assign unused_data_in = ^{data_in[DATA_W-1:5], data_in[1:0]};

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

   localparam int TO = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        ps2Clk = 1'b1;
   logic        ps2Data = 1'b1;
   logic        code_valid;
   logic        irq_o;

   int total = 0;
   int bad = 0;
   int cv_count = 0;

   ps2_rx_fifo #(
      .DATA_W(32), .FIFO_AW(3), .TIMEOUT_CYC(TO), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
      .data_in(data_in), .data_out(data_out),
      .ps2Clk(ps2Clk), .ps2Data(ps2Data),
      .code_valid(code_valid), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   // Count push pulses; sampled at the edge that performs the push.
   always @(posedge clk) if (code_valid === 1'b1) cv_count++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      sel = 1'b1; we = 1'b0; addr = a;
      #1 v = data_out;
      @(negedge clk);
      sel = 1'b0;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = a; data_in = d;
      @(negedge clk);
      sel = 1'b0; we = 1'b0; data_in = '0;
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2Data = b;
      repeat (5) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] code, input logic par, input logic stp);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(code[i]);
      ps2_bit(par);
      ps2_bit(stp);
      repeat (5) @(negedge clk);
   endtask

   task automatic send_good(input logic [7:0] code);
      send_frame(code, ~^code, 1'b1);
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  c;
      logic        cv_now;

      // ---- reset ----
      repeat (3) @(negedge clk);
      #1;
      chk("rst_irq", {31'd0, irq_o}, 32'd0);
      chk("rst_cv", {31'd0, code_valid}, 32'd0);
      chk("rst_dout", data_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus_rd(2'd0, v); chk("rst_status", v, 32'h001);
      bus_rd(2'd3, v); chk("addr3_rd", v, 32'h000);

      // ---- good frame 0x1C ----
      send_frame(8'h1C, 1'b0, 1'b1);
      chk("t1_cv", cv_count, 1);
      chk("t1_irq", {31'd0, irq_o}, 32'd1);
      bus_rd(2'd0, v); chk("t1_status", v, 32'h100);
      bus_rd(2'd1, v); chk("t1_data", v, 32'h01C);
      bus_rd(2'd0, v); chk("t1_status2", v, 32'h001);
      chk("t1_irq2", {31'd0, irq_o}, 32'd0);

      // ---- parity error 0xF0 ----
      send_frame(8'hF0, 1'b0, 1'b1);
      chk("t2_cv", cv_count, 1);
      bus_rd(2'd0, v); chk("t2_status", v, 32'h005);
      bus_wr(2'd2, 32'h4);
      bus_rd(2'd0, v); chk("t2_clear", v, 32'h001);

      // ---- timeout on partial frame ----
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      repeat (TO + 20) @(negedge clk);
      bus_rd(2'd0, v); chk("t3_status", v, 32'h009);
      send_good(8'h29);
      chk("t3_cv", cv_count, 2);
      bus_rd(2'd0, v); chk("t3_status2", v, 32'h108);
      bus_rd(2'd1, v); chk("t3_data", v, 32'h029);
      bus_wr(2'd2, 32'h8);
      bus_rd(2'd0, v); chk("t3_clear", v, 32'h001);

      // ---- overflow: 9 codes into depth 8 ----
      for (int i = 1; i <= 9; i++) begin
         c = 8'(i);
         send_good(c);
      end
      chk("t4_cv", cv_count, 10);
      bus_rd(2'd0, v); chk("t4_status", v, 32'h812);
      for (int i = 1; i <= 8; i++) begin
         bus_rd(2'd1, v); chk($sformatf("t4_data%0d", i), v, i);
      end
      bus_rd(2'd0, v); chk("t4_status2", v, 32'h011);
      bus_rd(2'd1, v); chk("t4_empty_rd", v, 32'h000);
      bus_rd(2'd0, v); chk("t4_status3", v, 32'h011);
      bus_wr(2'd2, 32'h10);
      bus_rd(2'd0, v); chk("t4_clear", v, 32'h001);

      // ---- pop coincides with push into a full FIFO ----
      for (int i = 0; i < 8; i++) begin
         c = 8'h11 + 8'(i);
         send_good(c);
      end
      chk("t5_cv", cv_count, 18);
      bus_rd(2'd0, v); chk("t5_status", v, 32'h802);
      c = 8'h19;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(c[i]);
      ps2_bit(~^c);
      @(negedge clk);
      ps2Data = 1'b1;
      repeat (5) @(negedge clk);
      ps2Clk = 1'b0;
      // Two sync flops, edge detect, then the push-pending cycle.
      repeat (3) @(negedge clk);
      sel = 1'b1; we = 1'b0; addr = 2'd1;
      #1 v = data_out; cv_now = code_valid;
      @(negedge clk);
      sel = 1'b0;
      chk("t5_pop_data", v, 32'h011);
      chk("t5_cv_pulse", {31'd0, cv_now}, 32'd1);
      repeat (9) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (10) @(negedge clk);
      chk("t5_cv2", cv_count, 19);
      bus_rd(2'd0, v); chk("t5_status2", v, 32'h802);
      for (int i = 0; i < 8; i++) begin
         bus_rd(2'd1, v); chk($sformatf("t5_data%0d", i), v, 32'h12 + i);
      end
      bus_rd(2'd0, v); chk("t5_status3", v, 32'h001);

      // ---- reset in the middle of a frame ----
      send_frame(8'h0F, 1'b0, 1'b1);
      send_good(8'h55);
      chk("t6_cv", cv_count, 20);
      bus_rd(2'd0, v); chk("t6_pre", v, 32'h104);
      ps2_bit(1'b0);
      c = 8'hF0;
      for (int i = 0; i < 5; i++) ps2_bit(c[i]);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("t6_rst_irq", {31'd0, irq_o}, 32'd0);
      chk("t6_rst_cv", {31'd0, code_valid}, 32'd0);
      chk("t6_rst_dout", data_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus_rd(2'd0, v); chk("t6_status", v, 32'h001);
      for (int i = 5; i < 8; i++) ps2_bit(c[i]);
      ps2_bit(~^c);
      ps2_bit(1'b1);
      repeat (TO + 20) @(negedge clk);
      chk("t6_cv2", cv_count, 20);
      bus_rd(2'd0, v); chk("t6_status2", v, 32'h001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
